// File: rtl/transformer_pkg.sv
// Shared types and the ReLU + requantise arithmetic used by the post-linear stages.
package transformer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_OUT_WIDTH = 16;
  localparam int MAX_OUT = 2**(DEF_OUT_WIDTH-1) - 1;

  typedef struct packed {
    logic [63:0] val;
    logic        sat;
  } rq_t;

  // Operates on a 64-bit sign-extended value so one function serves any WIDTH <= 64.
  function automatic rq_t relu_requant(input logic signed [63:0] x, input int shift,
                                       input int out_width);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    rq_t r;
    r  = '0;
    mx = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    if (x >= 0) begin
      s = x >>> shift;
      if (s > mx) begin
        r.val = mx;
        r.sat = 1'b1;
      end else begin
        r.val = s;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; head shows the last popped entry when empty.
module skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr is the one just popped, so the output holds.
  assign head = (count == 2'd0) ? mem[~rd_ptr] : mem[rd_ptr];

endmodule

// File: rtl/relu_requant_stage.sv
// ReLU, arithmetic right shift and saturation of one linear-layer vector per init,
// buffered through a 2-entry FIFO with an end-of-vector marker.
module relu_requant_stage
  import transformer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int VEC_LEN   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init,
  output logic                 ready,
  input  logic [WIDTH-1:0]     input_block,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic [OUT_WIDTH-1:0] output_block,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic                 output_last,
  output logic                 sat_flag
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);
  localparam logic [CW-1:0] VEC_END  = CW'(VEC_LEN);

  state_t                  state;
  logic [CW-1:0]           counter;
  logic [1:0]              fifo_count;
  logic [OUT_WIDTH:0]      head;
  logic                    accept;
  logic                    pop;
  logic                    is_last;
  logic signed [WIDTH-1:0] x_s;
  rq_t                     rq;
  logic                    unused_hi;

  assign x_s       = input_block;
  assign rq        = relu_requant(64'(x_s), SHIFT, OUT_WIDTH);
  assign unused_hi = ^rq.val[63:OUT_WIDTH];

  // Handshake terms come only from registered state; output_ready never reaches input_ready.
  assign ready        = (state == IDLE);
  assign input_ready  = (state == RUN) && (fifo_count < 2'd2) && (counter < VEC_END);
  assign accept       = input_valid && input_ready;
  assign is_last      = (counter == LAST_IDX);
  assign output_valid = (fifo_count != 2'd0);
  assign pop          = output_valid && output_ready;
  assign output_block = head[OUT_WIDTH-1:0];
  assign output_last  = output_valid && head[OUT_WIDTH];

  skid_fifo2 #(.W(OUT_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data ({is_last, rq.val[OUT_WIDTH-1:0]}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (init) begin
          state    <= RUN;
          counter  <= '0;
          sat_flag <= 1'b0;
        end
        RUN: if (accept) begin
          counter <= counter + 1'b1;
          if (rq.sat) sat_flag <= 1'b1;
          if (is_last) state <= DRAIN;
        end
        DRAIN: if (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_requant_stage.sv
// Directed bench for relu_requant_stage: a VEC_LEN=4 instance plus a VEC_LEN=1 instance.
module tb_relu_requant_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init, ready, input_valid, input_ready, output_valid, output_ready;
  logic        output_last, sat_flag;
  logic [31:0] input_block;
  logic [15:0] output_block;

  logic        init1, ready1, in1_valid, in1_ready, out1_valid, out1_ready, out1_last, sat1;
  logic [31:0] in1_block;
  logic [15:0] out1_block;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] din [4];
  logic [15:0] obs_blk [$];
  logic        obs_last [$];
  logic        obs_rdy [$];
  logic [1:0]  obs_cnt [$];
  int          obs_cyc [$];

  always #5 clk = ~clk;

  relu_requant_stage #(.WIDTH(32), .OUT_WIDTH(16), .SHIFT(8), .VEC_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .ready(ready),
    .input_block(input_block), .input_valid(input_valid), .input_ready(input_ready),
    .output_block(output_block), .output_valid(output_valid), .output_ready(output_ready),
    .output_last(output_last), .sat_flag(sat_flag)
  );

  relu_requant_stage #(.WIDTH(32), .OUT_WIDTH(16), .SHIFT(8), .VEC_LEN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .init(init1), .ready(ready1),
    .input_block(in1_block), .input_valid(in1_valid), .input_ready(in1_ready),
    .output_block(out1_block), .output_valid(out1_valid), .output_ready(out1_ready),
    .output_last(out1_last), .sat_flag(sat1)
  );

  function automatic logic [15:0] ref_rq(input logic [31:0] x);
    int q;
    if (x[31]) return 16'h0;
    q = int'(x[30:8]);
    return (q > 32767) ? 16'h7FFF : q[15:0];
  endfunction

  task automatic do_init;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Feeds din[first..n-1] and records every popped output; stops once drained.
  task automatic run_stream(input int first, input int n, input int cap);
    int idx = first;
    int cyc = 0;
    obs_blk.delete(); obs_last.delete(); obs_rdy.delete(); obs_cnt.delete(); obs_cyc.delete();
    while ((idx < n || output_valid) && cyc < cap) begin
      if (output_valid && output_ready) begin
        obs_blk.push_back(output_block);
        obs_last.push_back(output_last);
        obs_rdy.push_back(ready);
        obs_cnt.push_back(dut.u_fifo.count);
        obs_cyc.push_back(cyc);
      end
      if (idx < n) begin
        input_valid = 1'b1;
        input_block = din[idx];
        if (input_ready) idx++;
      end else begin
        input_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    input_valid = 1'b0;
    compared++;
    if (idx < n || output_valid) begin
      mismatched++;
      $display("FAIL stream_timeout: accepted %0d of %0d within %0d cycles", idx - first, n - first, cap);
    end
  endtask

  task automatic test_reset;
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", ready); end
    compared++; if (input_ready !== 1'b0) begin mismatched++; $display("FAIL rst_input_ready: got %b want 0", input_ready); end
    compared++; if (output_valid !== 1'b0) begin mismatched++; $display("FAIL rst_output_valid: got %b want 0", output_valid); end
    compared++; if (output_block !== 16'h0) begin mismatched++; $display("FAIL rst_output_block: got %h want 0000", output_block); end
    compared++; if (output_last !== 1'b0) begin mismatched++; $display("FAIL rst_output_last: got %b want 0", output_last); end
    compared++; if (sat_flag !== 1'b0) begin mismatched++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
    compared++; if (ready1 !== 1'b1) begin mismatched++; $display("FAIL rst_ready1: got %b want 1", ready1); end
    // Mid-vector reset: three accepts, one of them saturating, then pull reset.
    output_ready = 1'b1;
    din = '{32'h7FFFFFFF, 32'h00000200, 32'h00000300, 32'h0};
    do_init;
    run_stream(0, 3, 20);
    compared++; if (sat_flag !== 1'b1 || ready !== 1'b0) begin mismatched++; $display("FAIL midrun_pre: got sat=%b ready=%b want sat=1 ready=0", sat_flag, ready); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL midrun_rst_ready: got %b want 1", ready); end
    compared++; if (sat_flag !== 1'b0) begin mismatched++; $display("FAIL midrun_rst_sat: got %b want 0", sat_flag); end
    compared++; if (output_valid !== 1'b0 || output_block !== 16'h0 || output_last !== 1'b0) begin
      mismatched++; $display("FAIL midrun_rst_out: got v=%b blk=%h last=%b want 0/0000/0", output_valid, output_block, output_last);
    end
    compared++; if (input_ready !== 1'b0) begin mismatched++; $display("FAIL midrun_rst_input_ready: got %b want 0", input_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] eb [4];
    logic        el [4];
    eb = '{16'h0001, 16'h0000, 16'h0012, 16'h0000};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    output_ready = 1'b1;
    din = '{32'h00000100, 32'hFFFFFFFB, 32'h00001280, 32'h00000000};
    do_init;
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL basic_ready_low: got %b want 0", ready); end
    run_stream(0, 4, 20);
    compared++; if (obs_blk.size() !== 4) begin mismatched++; $display("FAIL basic_count: got %0d want 4", obs_blk.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (obs_blk[i] !== eb[i]) begin mismatched++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs_blk[i], eb[i]); end
      compared++; if (obs_last[i] !== el[i]) begin mismatched++; $display("FAIL basic_last[%0d]: got %b want %b", i, obs_last[i], el[i]); end
      compared++; if (obs_cyc[i] !== i + 1) begin mismatched++; $display("FAIL basic_latency[%0d]: got cycle %0d want %0d", i, obs_cyc[i], i + 1); end
    end
    compared++; if (obs_rdy[3] !== 1'b0) begin mismatched++; $display("FAIL basic_ready_at_last_pop: got %b want 0", obs_rdy[3]); end
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_saturation;
    logic [15:0] eb [4];
    eb = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001};
    output_ready = 1'b1;
    din = '{32'h7FFFFFFF, 32'h007FFF00, 32'hFFFFFFFF, 32'h00000100};
    do_init;
    run_stream(0, 4, 20);
    for (int i = 0; i < 4; i++) begin
      compared++; if (obs_blk[i] !== eb[i]) begin mismatched++; $display("FAIL sat_data[%0d]: got %h want %h", i, obs_blk[i], eb[i]); end
    end
    compared++; if (sat_flag !== 1'b1) begin mismatched++; $display("FAIL sat_sticky: got %b want 1", sat_flag); end
    do_init;
    compared++; if (sat_flag !== 1'b0) begin mismatched++; $display("FAIL sat_cleared_by_init: got %b want 0", sat_flag); end
    din = '{32'h007FFF00, 32'h0, 32'h0, 32'h0};
    run_stream(0, 4, 20);
    compared++; if (obs_blk[0] !== 16'h7FFF) begin mismatched++; $display("FAIL sat_boundary_data: got %h want 7fff", obs_blk[0]); end
    compared++; if (sat_flag !== 1'b0) begin mismatched++; $display("FAIL sat_boundary_flag: got %b want 0", sat_flag); end
  endtask

  task automatic test_backpressure;
    logic [15:0] eb [4];
    int idx = 0;
    eb = '{16'h0002, 16'h0003, 16'h0004, 16'h0005};
    din = '{32'h00000200, 32'h00000300, 32'h00000400, 32'h00000500};
    output_ready = 1'b0;
    do_init;
    input_valid = 1'b1;
    repeat (5) begin
      input_block = din[idx];
      if (input_ready) idx++;
      @(negedge clk);
    end
    input_valid = 1'b0;
    compared++; if (idx !== 2) begin mismatched++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    compared++; if (input_ready !== 1'b0) begin mismatched++; $display("FAIL bp_input_ready: got %b want 0", input_ready); end
    compared++; if (output_valid !== 1'b1 || output_block !== 16'h0002) begin
      mismatched++; $display("FAIL bp_head_hold: got v=%b blk=%h want 1/0002", output_valid, output_block);
    end
    output_ready = 1'b1;
    run_stream(2, 4, 20);
    compared++; if (obs_blk.size() !== 4) begin mismatched++; $display("FAIL bp_count: got %0d want 4", obs_blk.size()); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (obs_blk[i] !== eb[i]) begin mismatched++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_blk[i], eb[i]); end
      compared++; if (obs_cyc[i] !== i) begin mismatched++; $display("FAIL bp_rate[%0d]: got cycle %0d want %0d", i, obs_cyc[i], i); end
    end
  endtask

  task automatic test_random_stream;
    output_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       din[i] = {1'b1, 31'($urandom)};
          1:       din[i] = 32'($urandom_range(0, 32'h007FFFFF));
          2:       din[i] = $urandom;
          default: din[i] = {16'h007F, 8'hFF, 8'($urandom)} + 32'($urandom_range(0, 1) << 8);
        endcase
      end
      do_init;
      run_stream(0, 4, 20);
      for (int i = 0; i < 4; i++) begin
        compared++; if (obs_blk[i] !== ref_rq(din[i])) begin
          mismatched++; $display("FAIL rnd_data[%0d.%0d]: in %h got %h want %h", v, i, din[i], obs_blk[i], ref_rq(din[i]));
        end
        compared++; if (obs_cnt[i] !== 2'd1) begin mismatched++; $display("FAIL rnd_fifo_count[%0d.%0d]: got %0d want 1", v, i, obs_cnt[i]); end
      end
      compared++; if (obs_last[3] !== 1'b1 || obs_last[2] !== 1'b0) begin
        mismatched++; $display("FAIL rnd_last[%0d]: got %b%b want 01", v, obs_last[2], obs_last[3]);
      end
    end
  endtask

  task automatic test_protocol;
    output_ready = 1'b1;
    din = '{32'h00000100, 32'h7FFFFFFF, 32'h00000200, 32'h00000300};
    do_init;
    run_stream(0, 2, 20);
    do_init;
    compared++; if (ready !== 1'b0 || sat_flag !== 1'b1 || input_ready !== 1'b1) begin
      mismatched++; $display("FAIL proto_init_ignored: got ready=%b sat=%b in_rdy=%b want 0/1/1", ready, sat_flag, input_ready);
    end
    run_stream(2, 4, 20);
    compared++; if (obs_blk.size() !== 2) begin mismatched++; $display("FAIL proto_count: got %0d want 2", obs_blk.size()); end
    compared++; if (obs_blk[0] !== 16'h0002 || obs_blk[1] !== 16'h0003) begin
      mismatched++; $display("FAIL proto_data: got %h %h want 0002 0003", obs_blk[0], obs_blk[1]);
    end
    compared++; if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
      mismatched++; $display("FAIL proto_last: got %b%b want 01", obs_last[0], obs_last[1]);
    end
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL proto_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_vec1;
    out1_ready = 1'b1;
    init1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0;
    compared++; if (ready1 !== 1'b0 || in1_ready !== 1'b1) begin
      mismatched++; $display("FAIL v1_run: got ready=%b in_rdy=%b want 0/1", ready1, in1_ready);
    end
    in1_valid = 1'b1;
    in1_block = 32'h00000300;
    @(negedge clk);
    in1_valid = 1'b0;
    compared++; if (out1_valid !== 1'b1 || out1_block !== 16'h0003 || out1_last !== 1'b1) begin
      mismatched++; $display("FAIL v1_out: got v=%b blk=%h last=%b want 1/0003/1", out1_valid, out1_block, out1_last);
    end
    compared++; if (in1_ready !== 1'b0 || ready1 !== 1'b0) begin
      mismatched++; $display("FAIL v1_drain: got in_rdy=%b ready=%b want 0/0", in1_ready, ready1);
    end
    @(negedge clk);
    compared++; if (ready1 !== 1'b1 || out1_valid !== 1'b0) begin
      mismatched++; $display("FAIL v1_idle: got ready=%b v=%b want 1/0", ready1, out1_valid);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    init = 1'b0; input_valid = 1'b0; input_block = '0; output_ready = 1'b0;
    init1 = 1'b0; in1_valid = 1'b0; in1_block = '0; out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_saturation;
    test_backpressure;
    test_random_stream;
    test_protocol;
    test_vec1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
